irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl_defs.sv | 33 +++
 rtl/irq_sync_filter.sv | 46 ++++
 rtl/irq_ctrl.sv | 130 +++++++++++++
 tb/tb_irq_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_defs.sv
// Shared definitions for the interrupt controller.
// Holds the register offsets inside the 16-byte window, the CPU irq bit base,
// the channel count and a helper that decodes a byte offset to a register.
package irq_ctrl_defs;

  localparam int unsigned NUM_CH   = 3;
  localparam int unsigned IRQ_BASE = 5;

  localparam logic [3:0] OFF_PENDING = 4'h0;
  localparam logic [3:0] OFF_ENABLE  = 4'h4;
  localparam logic [3:0] OFF_MODE    = 4'h8;
  localparam logic [3:0] OFF_RAW     = 4'hC;

  typedef enum logic [1:0] {
    RegPending,
    RegEnable,
    RegMode,
    RegRaw
  } reg_sel_e;

  // Byte lanes [1:0] are ignored; every register is word aligned.
  function automatic reg_sel_e decode_reg(input logic [3:0] off);
    reg_sel_e sel;
    case (off & 4'hC)
      OFF_PENDING: sel = RegPending;
      OFF_ENABLE:  sel = RegEnable;
      OFF_MODE:    sel = RegMode;
      default:     sel = RegRaw;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/irq_sync_filter.sv
// Two-flop synchronizer followed by a glitch filter for one interrupt line.
// Ports:
//   clk, resetn : system clock, asynchronous active-low reset
//   i_line      : raw asynchronous input (active low, idle high)
//   o_filt      : filtered line level; changes only after the synchronized
//                 input has differed from it for FILTER_LEN consecutive cycles
module irq_sync_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_line,
  output logic o_filt
);

  localparam logic [3:0] CntMax = 4'(FILTER_LEN - 1);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_filt;
  logic [3:0] r_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_filt  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_line;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CntMax) begin
        // This is the FILTER_LEN-th consecutive differing cycle.
        r_filt <= r_sync2;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/irq_ctrl.sv
// Three-channel external interrupt controller on a picosoc-style iomem bus.
// Ports:
//   clk, resetn          : system clock, asynchronous active-low reset
//   irq_5, irq_6, irq_7  : external active-low interrupt lines (channels 0..2)
//   iomem_valid/wstrb/addr/wdata : bus request; wstrb == 0 is a read
//   iomem_ready          : one-cycle acknowledge, once per request
//   iomem_rdata          : read data while iomem_ready is high, else 0
//   irq                  : CPU interrupt vector, bits 5..7 = PENDING & ENABLE
//   eoi                  : CPU end-of-interrupt vector, bits 5..7 clear PENDING
// Registers: 0x0 PENDING (W1C), 0x4 ENABLE, 0x8 MODE (1 = edge), 0xC RAW (RO).
module irq_ctrl
  import irq_ctrl_defs::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        irq_5,
  input  logic        irq_6,
  input  logic        irq_7,
  input  logic        iomem_valid,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic        iomem_ready,
  output logic [31:0] iomem_rdata,
  output logic [31:0] irq,
  input  logic [31:0] eoi
);

  localparam int unsigned PadW = 32 - NUM_CH;

  logic [NUM_CH-1:0] w_line;
  logic [NUM_CH-1:0] w_filt;
  logic [NUM_CH-1:0] w_fall;
  logic [NUM_CH-1:0] w_set;
  logic [NUM_CH-1:0] w_clr;
  logic [NUM_CH-1:0] w_pending_d;
  logic              w_sel;
  logic              w_accept;
  logic              w_wr;
  reg_sel_e          w_reg;
  logic [31:0]       w_rdata_d;

  logic [NUM_CH-1:0] r_pending;
  logic [NUM_CH-1:0] r_enable;
  logic [NUM_CH-1:0] r_mode;
  logic [NUM_CH-1:0] r_filt_prev;
  logic              r_ready;
  logic              r_acked;
  logic [31:0]       r_rdata;

  assign w_line = {irq_7, irq_6, irq_5};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    irq_sync_filter #(
      .FILTER_LEN (FILTER_LEN)
    ) u_sync_filter (
      .clk    (clk),
      .resetn (resetn),
      .i_line (w_line[g]),
      .o_filt (w_filt[g])
    );
  end

  always_comb begin
    w_sel    = iomem_valid && (iomem_addr[31:4] == BASE_ADDR[31:4]);
    w_accept = w_sel && !r_acked;
    w_wr     = w_accept && iomem_wstrb[0];
    w_reg    = decode_reg(iomem_addr[3:0]);

    w_fall = r_filt_prev & ~w_filt;
    w_set  = (r_mode & w_fall) | (~r_mode & ~w_filt);
    w_clr  = eoi[IRQ_BASE +: NUM_CH];
    if (w_wr && (w_reg == RegPending)) begin
      w_clr = w_clr | iomem_wdata[NUM_CH-1:0];
    end
    // Set wins over a same-cycle clear.
    w_pending_d = w_set | (r_pending & ~w_clr);

    w_rdata_d = '0;
    unique case (w_reg)
      RegPending: w_rdata_d = {{PadW{1'b0}}, r_pending};
      RegEnable:  w_rdata_d = {{PadW{1'b0}}, r_enable};
      RegMode:    w_rdata_d = {{PadW{1'b0}}, r_mode};
      RegRaw:     w_rdata_d = {{PadW{1'b0}}, ~w_filt};
      default:    w_rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pending   <= '0;
      r_enable    <= '0;
      r_mode      <= '1;
      r_filt_prev <= '1;
      r_ready     <= 1'b0;
      // Start "already acknowledged" so a request straddling reset is never
      // acknowledged; valid must drop once before a new access is taken.
      r_acked     <= 1'b1;
      r_rdata     <= '0;
    end else begin
      r_filt_prev <= w_filt;
      r_pending   <= w_pending_d;
      r_ready     <= w_accept;
      r_acked     <= iomem_valid && (r_acked || w_accept);
      r_rdata     <= w_accept ? w_rdata_d : '0;
      if (w_wr && (w_reg == RegEnable)) begin
        r_enable <= iomem_wdata[NUM_CH-1:0];
      end
      if (w_wr && (w_reg == RegMode)) begin
        r_mode <= iomem_wdata[NUM_CH-1:0];
      end
    end
  end

  always_comb begin
    irq = '0;
    irq[IRQ_BASE +: NUM_CH] = r_pending & r_enable;
  end

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_ready ? r_rdata : '0;

  logic w_unused_bits;
  assign w_unused_bits = ^{iomem_wstrb[3:1], iomem_wdata[31:NUM_CH],
                           eoi[31:IRQ_BASE+NUM_CH], eoi[IRQ_BASE-1:0]};

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: a register vector table plus hand-written
// sequences for filter latency, glitch rejection, level mode, set/clear
// collision and bus/reset corner cases. Bus reads are scored by a monitor.
module tb_irq_ctrl;

  localparam logic [31:0] Base = 32'h0300_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        irq_5 = 1'b1;
  logic        irq_6 = 1'b1;
  logic        irq_7 = 1'b1;
  logic        iomem_valid = 1'b0;
  logic [3:0]  iomem_wstrb = '0;
  logic [31:0] iomem_addr = '0;
  logic [31:0] iomem_wdata = '0;
  logic        iomem_ready;
  logic [31:0] iomem_rdata;
  logic [31:0] irq;
  logic [31:0] eoi = '0;

  irq_ctrl #(
    .BASE_ADDR  (Base),
    .FILTER_LEN (4)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .irq_5       (irq_5),
    .irq_6       (irq_6),
    .irq_7       (irq_7),
    .iomem_valid (iomem_valid),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_ready (iomem_ready),
    .iomem_rdata (iomem_rdata),
    .irq         (irq),
    .eoi         (eoi)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cnt;

  typedef struct {
    logic        is_read;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [3:0]  off;
    logic [31:0] wdata;
    logic [3:0]  strb;   // 0: read only, no write
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Every acknowledge consumes one scoreboard entry; reads compare rdata.
  always @(negedge clk) begin
    if (iomem_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: got 1 want 0 at %0t", $time);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        if (e.is_read) check("bus_rdata", iomem_rdata, e.exp);
      end
    end
  end

  task automatic bus_access(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb);
    int n;
    @(posedge clk); #1;
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wdata = wdata;
    iomem_wstrb = strb;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (iomem_ready !== 1'b1 && n < 4);
    check("bus_ready_seen", {31'b0, iomem_ready}, 32'd1);
    iomem_valid = 1'b0;
    iomem_wstrb = '0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb);
    sb_q.push_back('{is_read: 1'b0, exp: '0});
    bus_access(addr, wdata, strb);
  endtask

  task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp);
    sb_q.push_back('{is_read: 1'b1, exp: exp});
    bus_access(addr, '0, 4'h0);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{off: 4'h0, wdata: 32'h0,         strb: 4'h0, exp: 32'h0};
    vecs[1]  = '{off: 4'h4, wdata: 32'h0,         strb: 4'h0, exp: 32'h0};
    vecs[2]  = '{off: 4'h8, wdata: 32'h0,         strb: 4'h0, exp: 32'h7};
    vecs[3]  = '{off: 4'hC, wdata: 32'h0,         strb: 4'h0, exp: 32'h0};
    vecs[4]  = '{off: 4'h4, wdata: 32'h7,         strb: 4'h1, exp: 32'h7};
    vecs[5]  = '{off: 4'h4, wdata: 32'hFFFF_FFF8, strb: 4'h1, exp: 32'h0};
    vecs[6]  = '{off: 4'h4, wdata: 32'h5,         strb: 4'hE, exp: 32'h0};
    vecs[7]  = '{off: 4'h8, wdata: 32'h2,         strb: 4'h1, exp: 32'h2};
    vecs[8]  = '{off: 4'h8, wdata: 32'h7,         strb: 4'hF, exp: 32'h7};
    vecs[9]  = '{off: 4'hC, wdata: 32'h7,         strb: 4'h1, exp: 32'h0};
    vecs[10] = '{off: 4'h0, wdata: 32'h7,         strb: 4'h1, exp: 32'h0};
    vecs[11] = '{off: 4'h5, wdata: 32'h6,         strb: 4'h1, exp: 32'h6};

    // Reset state
    cycles(2);
    check("rst_ready", {31'b0, iomem_ready}, 32'd0);
    check("rst_irq", irq, 32'd0);
    resetn = 1'b1;
    cycles(1);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].strb != 4'h0) bus_write(Base + 32'(vecs[i].off), vecs[i].wdata, vecs[i].strb);
      bus_read(Base + 32'(vecs[i].off), vecs[i].exp);
    end

    // Test 1: edge latency and W1C
    bus_write(Base + 32'h4, 32'h1, 4'h1);
    bus_write(Base + 32'h8, 32'h1, 4'h1);
    @(posedge clk); #1;
    irq_5 = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      @(posedge clk); #1;
      if (n == 6) check("t1_irq5_early", {31'b0, irq[5]}, 32'd0);
      if (n == 7) check("t1_irq5_latency", {31'b0, irq[5]}, 32'd1);
    end
    check("t1_irq_other_bits", irq & ~32'h20, 32'd0);
    cycles(3);
    irq_5 = 1'b1;
    bus_write(Base, 32'h1, 4'h1);
    check("t1_irq5_w1c", {31'b0, irq[5]}, 32'd0);
    cycles(10);
    bus_read(Base, 32'h0);
    bus_read(Base + 32'hC, 32'h0);

    // Test 2: glitch rejection on channel 1
    bus_write(Base + 32'h8, 32'h7, 4'h1);
    bus_write(Base + 32'h4, 32'h7, 4'h1);
    @(posedge clk); #1;
    irq_6 = 1'b0;
    cycles(3);
    irq_6 = 1'b1;
    cycles(12);
    bus_read(Base + 32'hC, 32'h0);
    bus_read(Base, 32'h0);
    @(posedge clk); #1;
    irq_6 = 1'b0;
    cycles(4);
    irq_6 = 1'b1;
    cycles(12);
    bus_read(Base, 32'h2);
    check("t2_irq6", {31'b0, irq[6]}, 32'd1);
    bus_write(Base, 32'h2, 4'h1);
    bus_read(Base, 32'h0);

    // Test 3: level mode on channel 2
    bus_write(Base + 32'h8, 32'h3, 4'h1);
    bus_write(Base + 32'h4, 32'h4, 4'h1);
    irq_7 = 1'b0;
    cycles(10);
    bus_read(Base + 32'hC, 32'h4);
    bus_read(Base, 32'h4);
    for (int k = 0; k < 3; k++) begin
      bus_write(Base, 32'h4, 4'h1);
      check("t3_level_reset", {31'b0, irq[7]}, 32'd1);
      cycles(3);
    end
    irq_7 = 1'b1;
    cycles(10);
    bus_write(Base, 32'h4, 4'h1);
    bus_read(Base, 32'h0);
    check("t3_irq7_released", {31'b0, irq[7]}, 32'd0);

    // Test 4: edge and W1C in the same cycle; disable/re-enable; eoi
    bus_write(Base + 32'h8, 32'h7, 4'h1);
    bus_write(Base + 32'h4, 32'h1, 4'h1);
    bus_write(Base, 32'h7, 4'h1);
    @(posedge clk); #1;
    irq_5 = 1'b0;
    cycles(6);
    sb_q.push_back('{is_read: 1'b0, exp: '0});
    iomem_valid = 1'b1;
    iomem_addr  = Base;
    iomem_wdata = 32'h1;
    iomem_wstrb = 4'h1;
    cycles(1);
    check("t4_ready", {31'b0, iomem_ready}, 32'd1);
    iomem_valid = 1'b0;
    iomem_wstrb = '0;
    check("t4_set_wins", {31'b0, irq[5]}, 32'd1);
    bus_write(Base + 32'h4, 32'h0, 4'h1);
    check("t4_disabled", {31'b0, irq[5]}, 32'd0);
    bus_read(Base, 32'h1);
    bus_write(Base + 32'h4, 32'h1, 4'h1);
    check("t4_reenabled", {31'b0, irq[5]}, 32'd1);
    @(posedge clk); #1;
    eoi = 32'h20;
    cycles(1);
    eoi = '0;
    check("t4_eoi", {31'b0, irq[5]}, 32'd0);
    bus_read(Base, 32'h0);
    irq_5 = 1'b1;
    cycles(10);

    // Test 5: address decode, single ready, reset mid-access
    @(posedge clk); #1;
    iomem_valid = 1'b1;
    iomem_addr  = Base + 32'h10;
    iomem_wstrb = 4'h0;
    cnt = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (iomem_ready === 1'b1) cnt++;
    end
    check("t5_unsel_ready", cnt, 0);
    check("t5_unsel_rdata", iomem_rdata, 32'h0);
    iomem_valid = 1'b0;
    @(posedge clk); #1;
    sb_q.push_back('{is_read: 1'b1, exp: 32'h1});
    iomem_valid = 1'b1;
    iomem_addr  = Base + 32'h4;
    cnt = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (iomem_ready === 1'b1) cnt++;
    end
    iomem_valid = 1'b0;
    check("t5_one_ready", cnt, 1);

    bus_write(Base + 32'h4, 32'h7, 4'h1);
    bus_write(Base + 32'h8, 32'h0, 4'h1);
    irq_6 = 1'b0;
    cycles(10);
    check("t5_pre_reset_irq6", {31'b0, irq[6]}, 32'd1);
    @(posedge clk); #1;
    iomem_valid = 1'b1;
    iomem_addr  = Base;
    cycles(1);
    check("t5_ready_pre_reset", {31'b0, iomem_ready}, 32'd1);
    resetn = 1'b0;
    irq_6  = 1'b1;
    #1;
    check("t5_rst_ready", {31'b0, iomem_ready}, 32'd0);
    check("t5_rst_irq", irq, 32'd0);
    cycles(3);
    resetn = 1'b1;
    cnt = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (iomem_ready === 1'b1) cnt++;
    end
    iomem_valid = 1'b0;
    check("t5_no_late_ack", cnt, 0);
    bus_read(Base, 32'h0);
    bus_read(Base + 32'h4, 32'h0);
    bus_read(Base + 32'h8, 32'h7);
    bus_read(Base + 32'hC, 32'h0);
    check("t5_post_reset_irq", irq, 32'd0);

    cycles(2);
    check("sb_drain", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
